// File: rtl/ahb_lite_cmd_master.sv
// AHB-Lite single-transfer master with a two-stage pipeline: the address stage
// (A) presents NONSEQ transfers and the data stage (D) completes them.
module ahb_lite_cmd_master (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [1:0]  cmd_size,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic [3:0]  HPROT,
  output logic        HMASTLOCK,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy,
  output logic [7:0]  err_count
);

  logic        a_valid_q, a_valid_d;
  logic [31:0] a_addr_q,  a_addr_d;
  logic        a_write_q, a_write_d;
  logic [2:0]  a_size_q,  a_size_d;
  logic [31:0] a_wdata_q, a_wdata_d;

  logic        d_valid_q, d_valid_d;
  logic        d_write_q, d_write_d;
  logic [31:0] d_wdata_q, d_wdata_d;

  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q,   rsp_err_d;
  logic [7:0]  err_count_q, err_count_d;

  logic        cmd_accept;
  logic        d_done;

  always_comb begin
    cmd_ready  = ~a_valid_q | HREADY;
    cmd_accept = cmd_valid & cmd_ready;
    d_done     = d_valid_q & HREADY;

    a_valid_d   = a_valid_q;
    a_addr_d    = a_addr_q;
    a_write_d   = a_write_q;
    a_size_d    = a_size_q;
    a_wdata_d   = a_wdata_q;
    d_valid_d   = d_valid_q;
    d_write_d   = d_write_q;
    d_wdata_d   = d_wdata_q;
    rsp_valid_d = d_done;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;

    // A keeps its address fields after it empties so HADDR/HWRITE/HSIZE hold during IDLE.
    if (cmd_accept) begin
      a_valid_d = 1'b1;
      a_addr_d  = cmd_addr;
      a_write_d = cmd_write;
      a_size_d  = (cmd_size == 2'd3) ? 3'b010 : {1'b0, cmd_size};
      a_wdata_d = cmd_wdata;
    end else if (HREADY) begin
      a_valid_d = 1'b0;
    end

    if (HREADY) begin
      d_valid_d = a_valid_q;
      d_write_d = a_write_q;
      d_wdata_d = a_wdata_q;
    end

    if (d_done) begin
      rsp_rdata_d = d_write_q ? 32'h0 : HRDATA;
      rsp_err_d   = HRESP;
      if (HRESP && (err_count_q != 8'hFF)) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_valid_q   <= 1'b0;
      a_addr_q    <= 32'h0;
      a_write_q   <= 1'b0;
      a_size_q    <= 3'b000;
      a_wdata_q   <= 32'h0;
      d_valid_q   <= 1'b0;
      d_write_q   <= 1'b0;
      d_wdata_q   <= 32'h0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
      err_count_q <= 8'h0;
    end else begin
      a_valid_q   <= a_valid_d;
      a_addr_q    <= a_addr_d;
      a_write_q   <= a_write_d;
      a_size_q    <= a_size_d;
      a_wdata_q   <= a_wdata_d;
      d_valid_q   <= d_valid_d;
      d_write_q   <= d_write_d;
      d_wdata_q   <= d_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign HTRANS    = a_valid_q ? 2'b10 : 2'b00;
  assign HADDR     = a_addr_q;
  assign HWRITE    = a_write_q;
  assign HSIZE     = a_size_q;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;
  assign HWDATA    = (d_valid_q && d_write_q) ? d_wdata_q : 32'h0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign err_count = err_count_q;
  assign busy      = a_valid_q | d_valid_q;

endmodule

// File: tb/tb_ahb_lite_cmd_master.sv
// Bench for ahb_lite_cmd_master: the bench plays the AHB slave and tracks
// outstanding commands as transaction queues to predict every output each cycle.
module tb_ahb_lite_cmd_master;

  logic        HCLK, HRESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [1:0]  cmd_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HMASTLOCK, HREADY, HRESP, busy;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [7:0]  err_count;

  ahb_lite_cmd_master dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_size(cmd_size),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
    .busy(busy), .err_count(err_count)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
  } cmd_t;

  cmd_t        aq[$];   // accepted, address phase not yet completed
  cmd_t        dq[$];   // in data phase
  logic        exp_rv, exp_re;
  logic [31:0] exp_rd;
  int          exp_ec;
  cmd_t        last_cmd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_clear();
    aq.delete();
    dq.delete();
    exp_rv = 1'b0;
    exp_re = 1'b0;
    exp_rd = 32'h0;
    exp_ec = 0;
    last_cmd.w = 1'b0;
    last_cmd.addr = 32'h0;
    last_cmd.wdata = 32'h0;
    last_cmd.size = 2'd0;
  endtask

  task automatic check_all();
    cmd_t        a;
    logic [2:0]  esz;
    logic [31:0] ewd;
    a   = (aq.size() > 0) ? aq[0] : last_cmd;
    esz = (a.size == 2'd3) ? 3'd2 : {1'b0, a.size};
    ewd = (dq.size() > 0 && dq[0].w) ? dq[0].wdata : 32'h0;
    chk("cmd_ready", {31'h0, cmd_ready}, {31'h0, (aq.size() == 0) || HREADY});
    chk("htrans",    {30'h0, HTRANS}, (aq.size() > 0) ? 32'd2 : 32'd0);
    chk("haddr",     HADDR, a.addr);
    chk("hwrite",    {31'h0, HWRITE}, {31'h0, a.w});
    chk("hsize",     {29'h0, HSIZE}, {29'h0, esz});
    chk("hwdata",    HWDATA, ewd);
    chk("busy",      {31'h0, busy}, {31'h0, (aq.size() > 0) || (dq.size() > 0)});
    chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rv});
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("rsp_err",   {31'h0, rsp_err}, {31'h0, exp_re});
    chk("err_count", {24'h0, err_count}, exp_ec);
    chk("consts",    {20'h0, HBURST, HPROT, 4'h0, 1'b0, HMASTLOCK}, {20'h0, 3'b000, 4'b0011, 4'h0, 1'b0, 1'b0});
  endtask

  task automatic model_edge(input logic cv, input cmd_t c, input logic hr, input logic hrsp,
                            input logic [31:0] hrd);
    logic rdy;
    cmd_t d;
    rdy    = (aq.size() == 0) || hr;
    exp_rv = 1'b0;
    if (hr && dq.size() > 0) begin
      d      = dq.pop_front();
      exp_rv = 1'b1;
      exp_rd = d.w ? 32'h0 : hrd;
      exp_re = hrsp;
      if (hrsp && exp_ec < 255) exp_ec++;
    end
    if (hr && aq.size() > 0) dq.push_back(aq.pop_front());
    if (cv && rdy) begin
      aq.push_back(c);
      last_cmd = c;
    end
  endtask

  task automatic step(input logic cv, input logic w, input logic [31:0] a, input logic [31:0] wd,
                      input logic [1:0] sz, input logic hr, input logic hrsp, input logic [31:0] hrd);
    cmd_t c;
    c.w = w; c.addr = a; c.wdata = wd; c.size = sz;
    cmd_valid = cv; cmd_write = w; cmd_addr = a; cmd_wdata = wd; cmd_size = sz;
    HREADY = hr; HRESP = hrsp; HRDATA = hrd;
    #1;
    check_all();
    @(posedge HCLK);
    model_edge(cv, c, hr, hrsp, hrd);
    @(negedge HCLK);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic do_reset();
    HRESETn   = 1'b0;
    cmd_valid = 1'b0;
    model_clear();
    #1;
    check_all();
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
  endtask

  initial begin
    HRESETn = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_size = 2'd0;
    HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0;
    model_clear();
    @(negedge HCLK);
    do_reset();
    idle(2);

    // Zero-wait word write
    step(1'b1, 1'b1, 32'h2000_0010, 32'hDEAD_BEEF, 2'd2, 1'b1, 1'b0, 32'h0);
    chk("w_htrans", {30'h0, HTRANS}, 32'd2);
    chk("w_hsize",  {29'h0, HSIZE}, 32'd2);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
    chk("w_hwdata", HWDATA, 32'hDEAD_BEEF);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
    chk("w_rsp", {30'h0, rsp_valid, rsp_err}, 32'd2);
    idle(2);

    // Back-to-back reads with two wait states on the first data phase
    step(1'b1, 1'b0, 32'h100, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h104, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'hBAD0_0000);
    chk("rr_wait_addr", HADDR, 32'h104);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'hBAD0_0001);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h1111_1111);
    chk("rr_first", rsp_rdata, 32'h1111_1111);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h2222_2222);
    chk("rr_second", rsp_rdata, 32'h2222_2222);
    idle(2);

    // Two-cycle ERROR response with a queued read behind it
    step(1'b1, 1'b0, 32'h200, 32'h0, 2'd1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h204, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b1, 32'h0);
    chk("err_rsp", {30'h0, rsp_valid, rsp_err}, 32'd3);
    chk("err_cnt1", {24'h0, err_count}, 32'd1);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b1, 1'b0, 32'h5555_AAAA);
    chk("err_next_ok", {30'h0, rsp_valid, rsp_err}, 32'd2);
    idle(2);

    // A full with HREADY stuck low, then accepted when HREADY rises
    step(1'b1, 1'b1, 32'h300, 32'h3333_0000, 2'd3, 1'b0, 1'b0, 32'h0);
    chk("sz3_hsize", {29'h0, HSIZE}, 32'd2);
    step(1'b1, 1'b0, 32'h400, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h400, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h400, 32'h0, 2'd0, 1'b1, 1'b0, 32'h0);
    chk("stall_accept", HADDR, 32'h400);
    idle(4);

    // Reset during a waited data phase with A occupied
    step(1'b1, 1'b0, 32'h500, 32'h0, 2'd2, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h504, 32'h7777_7777, 2'd2, 1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 32'h0);
    do_reset();
    idle(4);
    chk("post_rst_busy", {31'h0, busy}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
           2'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) == 0),
           $urandom);
    end
    idle(3);

    // err_count saturation
    for (int i = 0; i < 262; i++) begin
      step(1'b1, 1'b0, 32'h600, 32'h0, 2'd2, 1'b1, 1'b1, 32'h0);
    end
    idle(3);
    chk("err_sat", {24'h0, err_count}, 32'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
